// File: rtl/uop_fetch_seq.sv
// uop_fetch_seq
//   Sequencer between the microcode uop buffer and the issue stage. Walks the
//   uop buffer from a start address, pushes each two-slot bundle into a small
//   FIFO and presents the FIFO head downstream over valid/ready. Supports
//   end-of-microcode detection, redirect (flush + refetch) and branch-tag kill.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start/start_addr  begin sequencing (honoured in IDLE/DONE only)
//   uop_addr / uop    read address to the uop buffer / combinational bundle back
//   out_bundle/out_valid/out_ready  FIFO head, downstream handshake
//   kill_valid/kill_tag             clear slot valid bits carrying kill_tag
//   redirect_valid/redirect_addr    flush FIFO and refetch from redirect_addr
//   busy / done       state is FETCH or DRAIN / state is DONE
//
// Slot layout (slot1 at +36): [35:4] instruction, [3:2] tag, [1] valid, [0] ctl.
module uop_fetch_seq #(
  parameter int UOP_BUF_SIZE           = 128,
  parameter int UOP_BUF_WIDTH          = 72,
  parameter int MAX_PREDICT_DEPTH_BITS = 2,
  parameter int FIFO_DEPTH             = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [$clog2(UOP_BUF_SIZE)-1:0]   start_addr,
  output logic [$clog2(UOP_BUF_SIZE)-1:0]   uop_addr,
  input  logic [UOP_BUF_WIDTH-1:0]          uop,
  output logic [UOP_BUF_WIDTH-1:0]          out_bundle,
  output logic                              out_valid,
  input  logic                              out_ready,
  input  logic                              kill_valid,
  input  logic [MAX_PREDICT_DEPTH_BITS-1:0] kill_tag,
  input  logic                              redirect_valid,
  input  logic [$clog2(UOP_BUF_SIZE)-1:0]   redirect_addr,
  output logic                              busy,
  output logic                              done
);

  localparam int AW    = $clog2(UOP_BUF_SIZE);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int TB    = MAX_PREDICT_DEPTH_BITS;
  localparam int SLOT1 = 36;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            pc_q, pc_d, pc_inc;
  logic [PW-1:0]            rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [UOP_BUF_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [UOP_BUF_WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic                     can_fetch, is_term, push, pop;

  // Clear the valid bit of every slot whose tag matches the kill tag.
  function automatic logic [UOP_BUF_WIDTH-1:0] squash(
    input logic [UOP_BUF_WIDTH-1:0] b,
    input logic                     kv,
    input logic [TB-1:0]            kt
  );
    logic [UOP_BUF_WIDTH-1:0] r;
    r = b;
    if (kv && (b[2 +: TB] == kt))         r[1]         = 1'b0;
    if (kv && (b[SLOT1+2 +: TB] == kt))   r[SLOT1+1]   = 1'b0;
    return r;
  endfunction

  // Fetch decisions use the registered count only, so a pop this cycle
  // never frees a slot for a push in the same cycle.
  always_comb begin
    can_fetch = (state_q == S_FETCH) && (count_q != CW'(FIFO_DEPTH));
    // Terminator detection looks at the raw bundle, before any kill.
    is_term   = ~uop[SLOT1+1] & ~uop[1];
    push      = can_fetch && !is_term && !redirect_valid;
    pop       = out_valid && out_ready && !redirect_valid;
    pc_inc    = (pc_q == AW'(UOP_BUF_SIZE - 1)) ? '0 : pc_q + AW'(1);
  end

  // FIFO bookkeeping; redirect flushes and resets the pointers.
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    rd_d    = pop  ? rd_q + PW'(1) : rd_q;
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    if (redirect_valid) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end
  end

  // Every entry sees the kill in parallel; the entry being written takes the
  // squashed incoming bundle instead.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    assign fifo_d[gi] = (push && (wr_q == PW'(gi))) ? squash(uop, kill_valid, kill_tag)
                                                    : squash(fifo_q[gi], kill_valid, kill_tag);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Payload storage carries no reset: contents are meaningless while empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fifo_q[i] <= fifo_d[i];
    end
  end

  // Next-state logic. Redirect beats start and applies in every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = S_FETCH;
      pc_d    = redirect_addr;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_FETCH;
            pc_d    = start_addr;
          end
        end
        S_FETCH: begin
          if (can_fetch) begin
            if (is_term) state_d = S_DRAIN;
            else         pc_d    = pc_inc;
          end
        end
        S_DRAIN: begin
          if (count_d == '0) state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    uop_addr   = pc_q;
    out_valid  = (count_q != '0);
    out_bundle = fifo_q[rd_q];
    busy       = (state_q == S_FETCH) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_uop_fetch_seq.sv
// tb_uop_fetch_seq
//   Scoreboard bench for uop_fetch_seq. Starting a sequence pushes the whole
//   expected bundle stream (buffer contents from the start address up to the
//   first terminator) into a queue; a monitor pops and compares on every
//   accepted output. Kill and redirect update the queue from their rules.
module tb_uop_fetch_seq;
  localparam int AW = 7;
  localparam int W  = 72;
  localparam int N  = 128;

  logic          clk = 1'b0;
  logic          reset, start, out_valid, out_ready, kill_valid, redirect_valid, busy, done;
  logic [AW-1:0] start_addr, uop_addr, redirect_addr;
  logic [W-1:0]  uop, out_bundle;
  logic [1:0]    kill_tag;
  logic [W-1:0]  mem [N];

  always #5 clk = ~clk;
  assign uop = mem[uop_addr];

  uop_fetch_seq dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .uop_addr(uop_addr), .uop(uop), .out_bundle(out_bundle), .out_valid(out_valid),
    .out_ready(out_ready), .kill_valid(kill_valid), .kill_tag(kill_tag),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .busy(busy), .done(done)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_term(input logic [W-1:0] b);
    return (b[37] == 1'b0) && (b[1] == 1'b0);
  endfunction

  function automatic logic [W-1:0] kill_model(input logic [W-1:0] b, input logic [1:0] t);
    logic [W-1:0] r;
    r = b;
    for (int s = 0; s < 2; s++) begin
      if (b[s*36+2 +: 2] == t) r[s*36+1] = 1'b0;
    end
    return r;
  endfunction

  // Expected stream: bundles from addr, wrapping, up to the first terminator.
  task automatic expect_run(input int addr);
    int a;
    a = addr;
    for (int n = 0; n < N; n++) begin
      if (is_term(mem[a])) break;
      exp_q.push_back(mem[a]);
      a = (a + 1) % N;
    end
  endtask

  function automatic logic [35:0] mk_slot(input logic [31:0] ins, input logic [1:0] tag,
                                          input logic v, input logic c);
    return {ins, tag, v, c};
  endfunction

  function automatic logic [W-1:0] rnd_bundle(input bit term);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    if (term) begin
      r[37] = 1'b0;
      r[1]  = 1'b0;
    end else begin
      r[1] = 1'b1;
    end
    return r[W-1:0];
  endfunction

  task automatic clear_mem();
    for (int a = 0; a < N; a++) mem[a] = '0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %h expected no bundle", out_bundle);
      end else begin
        $display("tx pop bundle=%h", out_bundle);
        check("sb_bundle", out_bundle, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input int addr);
    expect_run(addr);
    start      = 1'b1;
    start_addr = AW'(addr);
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_done"}, W'(seen), W'(1));
    check({name, "_empty"}, W'(exp_q.size()), W'(0));
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, l, ra;
    reset = 1'b1; start = 1'b0; start_addr = '0; out_ready = 1'b0;
    kill_valid = 1'b0; kill_tag = '0; redirect_valid = 1'b0; redirect_addr = '0;
    clear_mem();
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_busy",  W'(busy), W'(0));
    check("rst_done",  W'(done), W'(0));
    check("rst_addr",  W'(uop_addr), W'(0));
    tick();

    // Basic sequence ending in a terminator
    mem[0] = {mk_slot(32'h1205021, 2'd2, 1'b1, 1'b1), mk_slot(32'h25270005, 2'd2, 1'b1, 1'b1)};
    mem[1] = {mk_slot(32'h25270004, 2'd2, 1'b1, 1'b1), mk_slot(32'h25270005, 2'd2, 1'b1, 1'b1)};
    mem[2] = {mk_slot(32'h25270004, 2'd2, 1'b1, 1'b1), mk_slot(32'h0, 2'd2, 1'b1, 1'b1)};
    mem[3] = '0;
    out_ready = 1'b1;
    do_start(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_addr",  W'(uop_addr), W'(i));
      check("t1_valid", W'(out_valid), W'(i > 0));
      tick();
    end
    @(negedge clk);
    check("t1_drain_busy", W'(busy), W'(1));
    check("t1_drain_done", W'(done), W'(0));
    tick();
    @(negedge clk);
    check("t1_done", W'(done), W'(1));
    check("t1_busy", W'(busy), W'(0));
    check("t1_empty", W'(exp_q.size()), W'(0));
    tick();

    // Back-pressure: FIFO fills to 4, pc stalls, then one per cycle
    clear_mem();
    for (int a = 0; a < 10; a++) mem[a] = rnd_bundle(1'b0);
    out_ready = 1'b0;
    do_start(0);
    repeat (8) tick();
    @(negedge clk);
    check("t2_stall_addr", W'(uop_addr), W'(4));
    check("t2_stall_valid", W'(out_valid), W'(1));
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_resume_addr", W'(uop_addr), W'(4));
    tick();
    @(negedge clk);
    check("t2_resume_addr", W'(uop_addr), W'(4));
    for (int k = 5; k < 9; k++) begin
      tick();
      @(negedge clk);
      check("t2_step_addr", W'(uop_addr), W'(k));
    end
    tick();
    wait_done("t2", 100, 1'b0);

    // Address wrap 127 -> 0
    clear_mem();
    mem[127] = rnd_bundle(1'b0);
    mem[0]   = rnd_bundle(1'b0);
    out_ready = 1'b1;
    do_start(127);
    @(negedge clk); check("t3_addr", W'(uop_addr), W'(127)); tick();
    @(negedge clk); check("t3_addr", W'(uop_addr), W'(0));   tick();
    @(negedge clk); check("t3_addr", W'(uop_addr), W'(1));   tick();
    wait_done("t3", 100, 1'b0);

    // Kill on queued entries
    clear_mem();
    mem[0] = {mk_slot($urandom(), 2'd2, 1'b1, 1'b1), mk_slot($urandom(), 2'd2, 1'b1, 1'b0)};
    mem[1] = {mk_slot($urandom(), 2'd2, 1'b1, 1'b0), mk_slot($urandom(), 2'd2, 1'b1, 1'b1)};
    out_ready = 1'b0;
    do_start(0);
    repeat (5) tick();
    kill_valid = 1'b1;
    kill_tag   = 2'd2;
    foreach (exp_q[i]) exp_q[i] = kill_model(exp_q[i], 2'd2);
    tick();
    kill_valid = 1'b0;
    @(negedge clk);
    check("t4_kill_head", out_bundle, exp_q[0]);
    check("t4_kill_v1", W'(out_bundle[37]), W'(0));
    check("t4_kill_v0", W'(out_bundle[1]), W'(0));
    tick();
    kill_valid = 1'b1;
    kill_tag   = 2'd1;
    foreach (exp_q[i]) exp_q[i] = kill_model(exp_q[i], 2'd1);
    tick();
    kill_valid = 1'b0;
    @(negedge clk);
    check("t4_nokill_head", out_bundle, exp_q[0]);
    tick();
    out_ready = 1'b1;
    wait_done("t4", 100, 1'b0);

    // Redirect with simultaneous kill and start
    clear_mem();
    for (int a = 0; a < 10; a++) mem[a] = rnd_bundle(1'b0);
    out_ready = 1'b0;
    do_start(0);
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_addr = 7'd5;
    kill_valid = 1'b1; kill_tag = 2'($urandom_range(0, 3));
    start = 1'b1; start_addr = 7'd64;
    exp_q.delete();
    expect_run(5);
    tick();
    redirect_valid = 1'b0; kill_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    check("t5_valid", W'(out_valid), W'(0));
    check("t5_addr", W'(uop_addr), W'(5));
    tick();
    out_ready = 1'b1;
    wait_done("t5", 100, 1'b0);

    // Reset in the middle of FETCH with a non-empty FIFO
    out_ready = 1'b0;
    do_start(0);
    repeat (2) tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_valid", W'(out_valid), W'(0));
    check("t6_addr", W'(uop_addr), W'(0));
    check("t6_busy", W'(busy), W'(0));
    check("t6_done", W'(done), W'(0));
    repeat (5) tick();
    @(negedge clk);
    check("t6_idle_busy", W'(busy), W'(0));
    tick();
    out_ready = 1'b1;
    do_start(0);
    wait_done("t6", 100, 1'b0);

    // Randomized runs with random back-pressure and optional redirect
    for (int it = 0; it < 25; it++) begin
      for (int a = 0; a < N; a++) mem[a] = rnd_bundle(1'b0);
      s = int'($urandom_range(0, N - 1));
      l = int'($urandom_range(0, 9));
      mem[(s + l) % N] = rnd_bundle(1'b1);
      out_ready = 1'($urandom_range(0, 1));
      do_start(s);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 4)) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        ra = (s + int'($urandom_range(0, l))) % N;
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr = AW'(ra);
        exp_q.delete();
        expect_run(ra);
        tick();
        redirect_valid = 1'b0;
      end
      wait_done("rnd", 1000, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
